// File: rtl/sobel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_buffer
// Description : Streaming 3x3 neighbourhood generator. Accepts raster-order
//               greyscale pixels, keeps the two previous rows in line
//               buffers and emits a registered 3x3 window for every
//               interior pixel, with valid/ready flow control on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_buffer #(
  parameter int IMG_WIDTH     = 20,
  parameter int IMG_HEIGHT    = 20,
  parameter int BIT_PER_PIXEL = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic [BIT_PER_PIXEL-1:0]      pix_in,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic [8:0][BIT_PER_PIXEL-1:0] win_out,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic                          win_last,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] C_COL_TWO  = CW'(2);
  localparam logic [RW-1:0] C_ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [RW-1:0]                   row_q, row_d;
  logic [8:0][BIT_PER_PIXEL-1:0]   win_q, win_d;
  logic                            win_valid_q, win_valid_d;
  logic                            win_last_q, win_last_d;

  // Line buffers: lb0 holds row r-2, lb1 holds row r-1, indexed by column.
  logic [BIT_PER_PIXEL-1:0]        lb0_q [IMG_WIDTH];
  logic [BIT_PER_PIXEL-1:0]        lb1_q [IMG_WIDTH];

  logic                            w_accept;
  logic                            w_xfer;
  logic                            w_col_last;
  logic                            w_frame_last;
  logic                            w_win_pos;
  logic [BIT_PER_PIXEL-1:0]        w_lb0_rd;
  logic [BIT_PER_PIXEL-1:0]        w_lb1_rd;

  assign w_lb0_rd     = lb0_q[col_q];
  assign w_lb1_rd     = lb1_q[col_q];
  assign w_col_last   = (col_q == C_COL_LAST);
  assign w_frame_last = w_col_last && (row_q == C_ROW_LAST);
  assign w_win_pos    = (col_q >= C_COL_TWO) && (row_q >= C_ROW_TWO);

  // Single output register: a new pixel may enter only if the window slot is
  // empty or is being drained this same cycle.
  assign pix_ready = (state_q == S_STREAM) && (!win_valid_q || win_ready);
  assign w_accept  = pix_valid && pix_ready;
  assign w_xfer    = win_valid_q && win_ready;

  assign win_out    = win_q;
  assign win_valid  = win_valid_q;
  assign win_last   = win_last_q;
  assign frame_done = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

  // Next-state, counter and window-register logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_STREAM;
          col_d       = '0;
          row_d       = '0;
          win_d       = '0;
          win_valid_d = 1'b0;
          win_last_d  = 1'b0;
        end
      end
      S_STREAM: begin
        if (w_xfer) begin
          win_valid_d = 1'b0;
          win_last_d  = 1'b0;
        end
        if (w_accept) begin
          // Shift window columns left; new right column is {r-2, r-1, r}.
          for (int ro = 0; ro < 3; ro++) begin
            win_d[3*ro]     = win_q[3*ro + 1];
            win_d[3*ro + 1] = win_q[3*ro + 2];
          end
          win_d[2] = w_lb0_rd;
          win_d[5] = w_lb1_rd;
          win_d[8] = pix_in;
          if (w_win_pos) begin
            win_valid_d = 1'b1;
            win_last_d  = w_frame_last;
          end
          if (w_frame_last) begin
            col_d   = '0;
            row_d   = '0;
            state_d = S_DRAIN;
          end else if (w_col_last) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        // The final accept always loads a window; leave once it is taken.
        if (w_xfer || !win_valid_q) begin
          win_valid_d = 1'b0;
          win_last_d  = 1'b0;
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and window registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  // Line buffers carry no reset: the first two rows of a frame overwrite
  // every entry before it is ever used in a window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      lb0_q[col_q] <= w_lb1_rd;
      lb1_q[col_q] <= pix_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_buffer
// Description : Directed bench for sobel_window_buffer. A 5x4 and a default
//               20x20 instance share stimulus; sel picks the one under test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_buffer;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             start = 1'b0;
  logic             pix_valid = 1'b0;
  logic             win_ready = 1'b0;
  logic [7:0]       pix_in = 8'd0;
  logic             sel = 1'b0;

  logic             pr_a, wv_a, wl_a, fd_a, bz_a;
  logic             pr_b, wv_b, wl_b, fd_b, bz_b;
  logic [8:0][7:0]  wo_a, wo_b;
  logic             start_a, start_b;

  logic             pix_ready, win_valid, win_last, frame_done, busy, other_ready;
  logic [8:0][7:0]  win_out;

  int               n_cmp = 0;
  int               n_err = 0;

  assign start_a     = start && !sel;
  assign start_b     = start && sel;
  assign pix_ready   = sel ? pr_b : pr_a;
  assign win_valid   = sel ? wv_b : wv_a;
  assign win_last    = sel ? wl_b : wl_a;
  assign frame_done  = sel ? fd_b : fd_a;
  assign busy        = sel ? bz_b : bz_a;
  assign win_out     = sel ? wo_b : wo_a;
  assign other_ready = sel ? pr_a : pr_b;

  always #5 clk = ~clk;

  sobel_window_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .BIT_PER_PIXEL(8)) u_dut_small (
    .clk(clk), .n_rst(n_rst), .start(start_a), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pr_a), .win_out(wo_a), .win_valid(wv_a),
    .win_ready(win_ready), .win_last(wl_a), .frame_done(fd_a), .busy(bz_a)
  );

  sobel_window_buffer u_dut_big (
    .clk(clk), .n_rst(n_rst), .start(start_b), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pr_b), .win_out(wo_b), .win_valid(wv_b),
    .win_ready(win_ready), .win_last(wl_b), .frame_done(fd_b), .busy(bz_b)
  );

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Image content: seed 0 gives the plain 10*r + c pattern.
  function automatic logic [7:0] pix(input int s, input int r, input int c);
    return 8'((s * 37 + r * 10 + c) & 255);
  endfunction

  // Drives one frame into the selected instance and checks every window.
  // rmode 1 toggles win_ready; vmode 1 randomises pix_valid; abort_after > 0
  // stops feeding after that many accepted pixels; stray pulses start mid-frame.
  task automatic run_frame(input int seed, input int rmode, input int vmode,
                           input int abort_after, input bit stray);
    int w, h, total, nwin, pi, widx, cyc, last_cyc, fd_cnt, r, c, wr, wc;
    bit exp_new, done;
    logic [8:0][7:0] e;
    w = sel ? 20 : 5;
    h = sel ? 20 : 4;
    total = w * h;
    nwin = (w - 2) * (h - 2);
    pi = 0; widx = 0; cyc = 0; last_cyc = -10; fd_cnt = 0;
    exp_new = 1'b0; done = 1'b0;
    @(negedge clk);
    start = 1'b1; pix_valid = 1'b0; win_ready = 1'b1;
    @(negedge clk);
    while (!done && cyc < 8000 && !(abort_after > 0 && pi >= abort_after)) begin
      win_ready = (rmode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (pi < total) pix_valid = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      else            pix_valid = 1'b0;
      r = pi / w;
      c = pi % w;
      pix_in = pix(seed, r, c);
      start = stray && (cyc == 7);
      #1;
      if (cyc == 3) check_val("idle_instance_ready", 72'(other_ready), 72'(0));
      if (rmode == 0)   check_val("valid_follows_window_pixel", 72'(win_valid), 72'(exp_new));
      else if (exp_new) check_val("window_latency", 72'(win_valid), 72'(1));
      exp_new = 1'b0;
      if (win_valid && !win_ready) check_val("stall_ready_low", 72'(pix_ready), 72'(0));
      if (frame_done) begin
        fd_cnt++;
        check_val("done_timing", 72'(cyc), 72'(last_cyc + 1));
        done = 1'b1;
      end
      if (win_valid && win_ready) begin
        wr = 2 + widx / (w - 2);
        wc = 2 + widx % (w - 2);
        for (int k = 0; k < 9; k++) e[k] = pix(seed, wr - 2 + k / 3, wc - 2 + k % 3);
        if (widx < nwin) begin
          check_val($sformatf("win%0d_data", widx), win_out, e);
          check_val($sformatf("win%0d_last", widx), 72'(win_last), 72'(widx == nwin - 1));
        end else begin
          check_val("extra_window", 72'(widx), 72'(nwin - 1));
        end
        if (widx == nwin - 1) last_cyc = cyc;
        widx++;
      end
      if (pix_valid && pix_ready) begin
        if (r >= 2 && c >= 2) exp_new = 1'b1;
        pi++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (abort_after == 0) begin
      check_val("frame_finished_in_budget", 72'(done), 72'(1));
      check_val("window_count", 72'(widx), 72'(nwin));
      check_val("frame_done_count", 72'(fd_cnt), 72'(1));
      check_val("pixels_accepted", 72'(pi), 72'(total));
      #1;
      check_val("idle_busy", 72'(busy), 72'(0));
      check_val("idle_frame_done", 72'(frame_done), 72'(0));
    end
  endtask

  initial begin
    // Reset state of both instances, with pix_valid asserted meanwhile.
    pix_valid = 1'b1;
    #3;
    check_val("rst_ready", 72'({pr_a, pr_b}), 72'(0));
    check_val("rst_valid", 72'({wv_a, wv_b}), 72'(0));
    check_val("rst_last", 72'({wl_a, wl_b}), 72'(0));
    check_val("rst_done", 72'({fd_a, fd_b}), 72'(0));
    check_val("rst_busy", 72'({bz_a, bz_b}), 72'(0));
    check_val("rst_win_a", wo_a, 72'(0));
    check_val("rst_win_b", wo_b, 72'(0));
    @(negedge clk);
    n_rst = 1'b1;
    // pix_valid held in IDLE must not be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_val("idle_no_accept", 72'({pr_a, pr_b, bz_a, bz_b}), 72'(0));
    end

    // 5x4 frames: full rate with stray start, toggled ready, random valid.
    sel = 1'b0;
    run_frame(0, 0, 0, 0, 1'b1);
    run_frame(0, 1, 0, 0, 1'b0);
    run_frame(5, 0, 1, 0, 1'b0);

    // 20x20 frames back to back with different data.
    sel = 1'b1;
    run_frame(0, 0, 0, 0, 1'b0);
    run_frame(1, 0, 0, 0, 1'b0);

    // Abort after 30 pixels with reset, then a clean frame.
    run_frame(3, 0, 0, 30, 1'b0);
    n_rst = 1'b0;
    pix_valid = 1'b0;
    #1;
    check_val("abort_ready", 72'(pr_b), 72'(0));
    check_val("abort_valid", 72'(wv_b), 72'(0));
    check_val("abort_last", 72'(wl_b), 72'(0));
    check_val("abort_done", 72'(fd_b), 72'(0));
    check_val("abort_busy", 72'(bz_b), 72'(0));
    check_val("abort_win", wo_b, 72'(0));
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_val("post_abort_quiet", 72'({fd_b, bz_b}), 72'(0));
    end
    run_frame(4, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_window_buffer.md
# sobel_window_buffer

Streaming 3x3 neighbourhood generator for the edge-detection datapath. Sits directly downstream of the SRAM pixel controller: accepts greyscale pixels in raster order, one per handshake, and keeps the two previous image rows in on-chip line buffers. For every interior pixel position it emits a registered 3x3 window to the gradient stage, with valid/ready backpressure in both directions.

## Interface
- IMG_WIDTH, 20, pixels per row (>= 3)
- IMG_HEIGHT, 20, rows per frame (>= 3)
- BIT_PER_PIXEL, 8, greyscale pixel width
- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise
- pix_in  in  BIT_PER_PIXEL  greyscale pixel from pixel controller
- pix_valid  in  1  pix_in is valid
- pix_ready  out  1  block accepts pix_in this cycle
- win_out  out  [8:0][BIT_PER_PIXEL-1:0]  window; index = 3*rowoff + coloff; rowoff 0 = row r-2, coloff 0 = column c-2; win_out[8] = newest pixel
- win_valid  out  1  win_out holds an undelivered window
- win_ready  in  1  downstream accepts window
- win_last  out  1  qualifies the final window of the frame
- frame_done  out  1  one-cycle pulse after the final window is delivered
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: pix_ready=0, busy=0. start=1 -> clear row/col counters and window registers -> STREAM. Line buffer contents are not cleared; the first two rows overwrite them before any use.
- STREAM: pix_ready = !win_valid || win_ready (single output register). Accept = pix_valid && pix_ready.
- On accept at (r,c): read L1[c] (row r-1) and L0[c] (row r-2); write L0[c]<=L1[c], L1[c]<=pix_in; shift window columns left; new right column = {L0[c], L1[c], pix_in}.
- Window load: if r>=2 && c>=2, set win_valid=1 and win_last=(r==IMG_HEIGHT-1 && c==IMG_WIDTH-1); otherwise the window registers shift but win_valid is not set by this accept.
- win_valid clears on win_valid && win_ready, unless a new window loads in the same cycle, in which case it stays 1 with the new data.
- Counters: c increments per accept and wraps IMG_WIDTH-1 -> 0 with r+1; widths $clog2(IMG_WIDTH), $clog2(IMG_HEIGHT). The final accept (r=IMG_HEIGHT-1, c=IMG_WIDTH-1) moves the FSM to DRAIN.
- DRAIN: pix_ready=0. Hold win_out until win_ready. When the last window transfers -> DONE.
- DONE: frame_done=1 for exactly one cycle -> IDLE.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Row-edge columns never produce a window; the left two columns of a row reuse the shift registers with no special clearing.
- pix_valid while not in STREAM: ignored, since pix_ready=0.

## Timing
- Reset values: pix_ready=0, win_out=0, win_valid=0, win_last=0, frame_done=0, busy=0, state=IDLE, counters=0.
- Reset mid-frame aborts immediately. No frame_done is issued. A new start is required.
- Latency: pixel accepted at edge k -> its window is visible on win_out/win_valid after edge k (one cycle).
- Throughput: one pixel and one window per cycle when win_ready is held high.
- Stall: win_valid=1 && win_ready=0 -> pix_ready=0 combinationally; win_out and win_last hold stable.
- start during STREAM, DRAIN or DONE: no effect.
- Line buffers: two IMG_WIDTH x BIT_PER_PIXEL register arrays, one read and one write per array per accept, same address.

## Test plan
- W=5, H=4 override, pixel value = 10*r + c, win_ready=1 -> exactly 6 windows. The first window arrives after the accept of (2,2) and equals {0,1,2,10,11,12,20,21,22}. The last window has win_last=1, and frame_done pulses exactly 1 cycle later.
- Same frame with win_ready toggling 1/0 every cycle -> identical window sequence, no loss or duplication; pix_ready is low on every cycle where win_valid=1 and win_ready=0.
- pix_valid random 50% with win_ready=1 -> window contents match a software 3x3 model; win_valid only follows accepted pixels at c>=2, r>=2.
- Default 20x20 frame, then a second start with new data -> 324 windows per frame, and second-frame windows contain no first-frame pixels.
- Assert n_rst low after 30 pixels -> all outputs return to reset values, busy=0, no frame_done. A fresh start then produces a correct full frame.
- start pulsed during STREAM and pix_valid held high in IDLE -> counters unaffected, no pixels accepted in IDLE.
